// File: rtl/cfg_regs_pkg.sv
// Shared definitions for the configuration register bank: sizes, FSM encoding,
// register addresses and small address helpers.
package cfg_regs_pkg;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [ADDR_W-1:0] REG0_ADDR = 7'd0;
    localparam logic [ADDR_W-1:0] REG1_ADDR = 7'd1;
    localparam logic [ADDR_W-1:0] REG2_ADDR = 7'd2;
    localparam logic [ADDR_W-1:0] REG3_ADDR = 7'd3;
    localparam logic [ADDR_W-1:0] REG4_ADDR = 7'd4;

    // Full-width unsigned compare; upper address bits must not alias onto the bank.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_REGS);
    endfunction

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (addr == ADDR_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request bus for the two register bank writers (SPI decoder on A, sequencer on B).
interface reg_write_arbiter_if;
    import cfg_regs_pkg::*;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the caller owns and updates last_grant.
module rr_arb2
    import cfg_regs_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    input  logic       en,
    output logic       gnt_valid,
    output port_t      gnt_id
);

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_id    = PORT_A;
        if (req == 2'b11) begin
            gnt_id = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req[1]) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Sole writer of the 5 x 8-bit configuration bank: arbitrates ports A/B round-robin,
// performs one checked write per grant and pulses ready/strobe/err in the ACK cycle.
module reg_write_arbiter
    import cfg_regs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    reg_write_arbiter_if.slave  bus,
    input  logic                lock,
    output logic [DATA_W-1:0]   reg0,
    output logic [DATA_W-1:0]   reg1,
    output logic [DATA_W-1:0]   reg2,
    output logic [DATA_W-1:0]   reg3,
    output logic [DATA_W-1:0]   reg4,
    output logic [NUM_REGS-1:0] upd_strobe,
    output logic                err,
    output logic                busy
);

    state_t            state;
    state_t            state_next;
    port_t             last_grant;
    port_t             cap_id;
    port_t             gnt_id;
    logic              gnt_valid;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] bank [NUM_REGS];
    logic              a_ready_q;
    logic              b_ready_q;

    rr_arb2 u_arb (
        .req        ({bus.b_valid, bus.a_valid}),
        .last_grant (last_grant),
        .en         ((state == IDLE) && !lock),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_valid) state_next = WRITE;
            WRITE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset leaves last_grant at B so that A wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
            cap_id     <= PORT_A;
            cap_addr   <= '0;
            cap_data   <= '0;
        end else if (gnt_valid) begin
            last_grant <= gnt_id;
            cap_id     <= gnt_id;
            cap_addr   <= (gnt_id == PORT_B) ? bus.b_addr : bus.a_addr;
            cap_data   <= (gnt_id == PORT_B) ? bus.b_data : bus.a_data;
        end
    end

    // The bank write and the ACK-cycle pulses are both produced at the end of WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
            upd_strobe <= '0;
            err        <= 1'b0;
            a_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
        end else begin
            upd_strobe <= '0;
            err        <= 1'b0;
            a_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            if (state == WRITE) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cap_addr == ADDR_W'(i)) begin
                        bank[i] <= cap_data;
                    end
                end
                upd_strobe <= addr_onehot(cap_addr);
                err        <= !addr_in_range(cap_addr);
                a_ready_q  <= (cap_id == PORT_A);
                b_ready_q  <= (cap_id == PORT_B);
            end
        end
    end

    assign bus.a_ready = a_ready_q;
    assign bus.b_ready = b_ready_q;
    assign busy        = (state != IDLE);
    assign reg0        = bank[0];
    assign reg1        = bank[1];
    assign reg2        = bank[2];
    assign reg3        = bank[3];
    assign reg4        = bank[4];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of grants, writes and ACK pulses.
module tb_reg_write_arbiter;
    import cfg_regs_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                lock;
    logic [DATA_W-1:0]   reg0, reg1, reg2, reg3, reg4;
    logic [NUM_REGS-1:0] upd_strobe;
    logic                err;
    logic                busy;

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .lock       (lock),
        .reg0       (reg0),
        .reg1       (reg1),
        .reg2       (reg2),
        .reg3       (reg3),
        .reg4       (reg4),
        .upd_strobe (upd_strobe),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic checking = 1'b0;

    // Model: bank contents, the one in-flight grant and the outputs expected next cycle.
    logic [DATA_W-1:0]   m_regs [NUM_REGS];
    logic                inflight = 1'b0;
    logic                g_port_b = 1'b0;
    int                  g_addr = 0;
    logic [DATA_W-1:0]   g_data = '0;
    int                  g_cycle = 0;
    int                  cyc = 0;
    logic                last_b = 1'b1;
    logic                exp_a_ready = 1'b0, exp_b_ready = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [NUM_REGS-1:0] exp_strobe = '0;
    logic                seen_a = 1'b0, seen_b = 1'b0;
    int                  order [$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        logic free;
        seen_a = exp_a_ready;
        seen_b = exp_b_ready;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            inflight = 1'b0;
            last_b = 1'b1;
            exp_a_ready = 1'b0; exp_b_ready = 1'b0; exp_err = 1'b0; exp_strobe = '0; exp_busy = 1'b0;
        end else begin
            free = !inflight;
            exp_a_ready = 1'b0; exp_b_ready = 1'b0; exp_err = 1'b0; exp_strobe = '0;
            if (inflight && cyc == g_cycle + 1) begin
                if (g_addr < NUM_REGS) begin
                    m_regs[g_addr] = g_data;
                    exp_strobe = NUM_REGS'(1) << g_addr;
                end else begin
                    exp_err = 1'b1;
                end
                if (g_port_b) exp_b_ready = 1'b1;
                else          exp_a_ready = 1'b1;
            end
            if (inflight && cyc == g_cycle + 2) inflight = 1'b0;
            if (free && !lock && (bus.a_valid || bus.b_valid)) begin
                g_port_b = (bus.a_valid && bus.b_valid) ? !last_b : bus.b_valid;
                g_addr   = g_port_b ? int'(bus.b_addr) : int'(bus.a_addr);
                g_data   = g_port_b ? bus.b_data : bus.a_data;
                g_cycle  = cyc;
                inflight = 1'b1;
                last_b   = g_port_b;
            end
            exp_busy = inflight;
        end
        cyc++;
    endtask

    // One clock: compare at negedge (other process), model at posedge, then requesters drop on ready.
    task automatic tick();
        @(posedge clk);
        model_step();
        checking = 1'b1;
        #1;
        if (seen_a) bus.a_valid = 1'b0;
        if (seen_b) bus.b_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic port_b, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (port_b) begin
            bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
        end else begin
            bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("a_ready", bus.a_ready, exp_a_ready);
            check_output("b_ready", bus.b_ready, exp_b_ready);
            check_output("err", err, exp_err);
            check_output("busy", busy, exp_busy);
            check_output("upd_strobe", upd_strobe, exp_strobe);
            check_output("reg0", reg0, m_regs[0]);
            check_output("reg1", reg1, m_regs[1]);
            check_output("reg2", reg2, m_regs[2]);
            check_output("reg3", reg3, m_regs[3]);
            check_output("reg4", reg4, m_regs[4]);
        end
    end

    initial begin
        rst_n = 1'b0; lock = 1'b0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        check_output("rst_busy", busy, 0);
        check_output("rst_reg2", reg2, 0);
        check_output("rst_strobe", upd_strobe, 0);

        // Single write from A
        apply_stimulus(1'b0, 7'd2, 8'h5A);
        tick(); tick();
        check_output("t1_a_ready", bus.a_ready, 1);
        check_output("t1_reg2", reg2, 8'h5A);
        check_output("t1_strobe", upd_strobe, 5'b00100);
        check_output("t1_model_reg2", m_regs[2], 8'h5A);
        check_output("t1_reg0", reg0, 0);
        tick(); tick();

        // Contention right after reset: A first, B three cycles later
        do_reset();
        apply_stimulus(1'b0, 7'd0, 8'h11);
        apply_stimulus(1'b1, 7'd1, 8'h22);
        tick(); tick();
        check_output("t2_a_first", bus.a_ready, 1);
        check_output("t2_b_not_yet", bus.b_ready, 0);
        tick(); tick(); tick();
        check_output("t2_b_second", bus.b_ready, 1);
        check_output("t2_a_quiet", bus.a_ready, 0);
        check_output("t2_reg0", reg0, 8'h11);
        check_output("t2_reg1", reg1, 8'h22);
        tick(); tick();

        // Out-of-range address from B
        apply_stimulus(1'b1, 7'd5, 8'hFF);
        tick(); tick();
        check_output("t3_b_ready", bus.b_ready, 1);
        check_output("t3_err", err, 1);
        check_output("t3_strobe", upd_strobe, 0);
        check_output("t3_reg1", reg1, 8'h22);
        tick(); tick();

        // Lock holds off a pending request; lock during WRITE does not stop it
        lock = 1'b1;
        apply_stimulus(1'b0, 7'd3, 8'h33);
        tick(); tick(); tick(); tick();
        check_output("t4_locked_busy", busy, 0);
        check_output("t4_locked_ready", bus.a_ready, 0);
        lock = 1'b0;
        tick(); tick();
        check_output("t4_a_ready", bus.a_ready, 1);
        check_output("t4_reg3", reg3, 8'h33);
        tick();
        apply_stimulus(1'b0, 7'd4, 8'h44);
        tick();
        lock = 1'b1;
        tick();
        check_output("t4_inflight_ready", bus.a_ready, 1);
        check_output("t4_reg4", reg4, 8'h44);
        tick();
        lock = 1'b0;
        tick();

        // Reset during WRITE drops the write and the ready pulse
        apply_stimulus(1'b0, 7'd0, 8'h77);
        tick();
        do_reset();
        check_output("t5_busy", busy, 0);
        check_output("t5_a_ready", bus.a_ready, 0);
        check_output("t5_reg0", reg0, 0);
        check_output("t5_reg4", reg4, 0);
        tick(); tick(); tick(); tick();

        // Fairness: both ports always requesting with fresh data
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        do_reset();
        begin
            int na = 1;
            int nb = 1;
            apply_stimulus(1'b0, 7'd0, 8'hA1);
            apply_stimulus(1'b1, 7'd1, 8'hB1);
            for (int i = 0; i < 40 && order.size() < 6; i++) begin
                tick();
                if (seen_a) order.push_back(0);
                if (seen_b) order.push_back(1);
                if (!bus.a_valid) begin na++; apply_stimulus(1'b0, 7'd0, 8'(8'hA0 + na)); end
                if (!bus.b_valid) begin nb++; apply_stimulus(1'b1, 7'd1, 8'(8'hB0 + nb)); end
            end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        check_output("t6_grants", order.size(), 6);
        for (int i = 0; i < order.size(); i++) begin
            check_output($sformatf("t6_order%0d", i), order[i], i % 2);
        end
        check_output("t6_reg0", reg0, 8'hA3);
        check_output("t6_reg1", reg1, 8'hB3);
        check_output("t6_model_reg1", m_regs[1], 8'hB3);
        tick(); tick(); tick();

        // Random traffic: mixed addresses, occasional lock and reset
        for (int i = 0; i < 2000; i++) begin
            tick();
            lock  = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            if (!bus.a_valid && $urandom_range(0, 2) == 0)
                apply_stimulus(1'b0, ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4)), 8'($urandom));
            if (!bus.b_valid && $urandom_range(0, 2) == 0)
                apply_stimulus(1'b1, ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4)), 8'($urandom));
        end
        rst_n = 1'b1; lock = 1'b0;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
